sddt_cmd_arbiter: RTL and testbench

Arbitrates the 128-bit DDR4 command stream into `sddt_core` between the host command stream and an internal periodic-refresh generator. It sits between `ps_interface` (M_AXIS_CMD) and `sddt_core` (S_AXIS_CMD) in the `c0_ddr4_clk` domain. Host commands normally take priority, refreshes are postponed up to a bounded debt, and a refresh becomes urgent when that debt is exhausted. A single registered output slice provides one-cycle forwarding latency.

---
 rtl/sddt_pkg.sv | 25 ++
 rtl/sddt_ref_timer.sv | 75 +++++++
 rtl/sddt_cmd_arbiter.sv | 112 +++++++++++
 tb/tb_sddt_cmd_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sddt_pkg.sv
// Shared types and constants for the SDDT command path: command word layout,
// the all-bank refresh encoding and the arbiter state enum.
package sddt_pkg;

    localparam int unsigned SDDT_CMD_W    = 128;
    localparam int unsigned SDDT_OPC_W    = 4;
    localparam int unsigned SDDT_PEND_W   = 4;
    localparam int unsigned SDDT_ISSUED_W = 32;

    localparam logic [SDDT_OPC_W-1:0] SDDT_OPC_REF = 4'h3;

    // Command word: opcode in the top nibble, everything else opcode-specific.
    typedef struct packed {
        logic [SDDT_OPC_W-1:0]            opcode;
        logic [SDDT_CMD_W-SDDT_OPC_W-1:0] body;
    } sddt_cmd_t;

    localparam sddt_cmd_t SDDT_REF_CMD = '{opcode: SDDT_OPC_REF, body: '0};

    typedef enum logic {
        NORMAL = 1'b0,
        URGENT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sddt_ref_timer.sv
// Periodic refresh timer and refresh-debt bookkeeping.
// Ports:
//   c0_ddr4_clk, c0_ddr4_rst : clock, synchronous active-high reset
//   ref_en                   : run the interval timer
//   ref_issue                : a refresh word is being loaded downstream this cycle
//   ref_pending              : outstanding refresh debt (saturates at MAX_POSTPONE)
//   ref_overflow             : sticky, a tick was lost because debt was saturated
module sddt_ref_timer
    import sddt_pkg::*;
#(
    parameter int unsigned TREFI_CYCLES = 1300,
    parameter int unsigned MAX_POSTPONE = 8
) (
    input  logic                   c0_ddr4_clk,
    input  logic                   c0_ddr4_rst,
    input  logic                   ref_en,
    input  logic                   ref_issue,
    output logic [SDDT_PEND_W-1:0] ref_pending,
    output logic                   ref_overflow
);

    localparam int unsigned TMR_W = (TREFI_CYCLES > 1) ? $clog2(TREFI_CYCLES) : 1;
    localparam logic [TMR_W-1:0]       TMR_LAST = TMR_W'(TREFI_CYCLES - 1);
    localparam logic [SDDT_PEND_W-1:0] PEND_MAX = SDDT_PEND_W'(MAX_POSTPONE);

    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   tick_c;
    logic [SDDT_PEND_W-1:0] pend_q, pend_d;
    logic                   ovf_q, ovf_d;

    // Interval timer: holds its phase while disabled.
    always_comb begin
        tmr_d  = tmr_q;
        tick_c = 1'b0;
        if (ref_en) begin
            if (tmr_q == TMR_LAST) begin
                tmr_d  = '0;
                tick_c = 1'b1;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end
    end

    // Debt: a tick adds one, an issue removes one, both together cancel.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (tick_c && !ref_issue) begin
            if (pend_q >= PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + SDDT_PEND_W'(1);
            end
        end else if (ref_issue && !tick_c && (pend_q != '0)) begin
            pend_d = pend_q - SDDT_PEND_W'(1);
        end
    end

    always_ff @(posedge c0_ddr4_clk) begin
        if (c0_ddr4_rst) begin
            tmr_q  <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign ref_pending  = pend_q;
    assign ref_overflow = ovf_q;

endmodule

// File: rtl/sddt_cmd_arbiter.sv
// Merges the host DDR4 command stream with periodic all-bank refreshes into a
// single registered output slot feeding sddt_core.
// Ports:
//   c0_ddr4_clk, c0_ddr4_rst : clock, synchronous active-high reset
//   ref_en                   : enable refresh timing and refresh issue
//   S_AXIS_HOST_*            : host command stream in (tready combinational)
//   M_AXIS_CMD_*             : command stream out to sddt_core (registered)
//   ref_pending              : current refresh debt
//   ref_issued               : refresh words handed off downstream (wraps)
//   ref_overflow             : sticky, a refresh interval was lost
module sddt_cmd_arbiter
    import sddt_pkg::*;
#(
    parameter int unsigned          CMD_WIDTH    = SDDT_CMD_W,
    parameter int unsigned          TREFI_CYCLES = 1300,
    parameter int unsigned          MAX_POSTPONE = 8,
    parameter logic [CMD_WIDTH-1:0] REF_CMD      = CMD_WIDTH'(SDDT_REF_CMD)
) (
    input  logic                     c0_ddr4_clk,
    input  logic                     c0_ddr4_rst,
    input  logic                     ref_en,
    input  logic [CMD_WIDTH-1:0]     S_AXIS_HOST_tdata,
    input  logic                     S_AXIS_HOST_tvalid,
    output logic                     S_AXIS_HOST_tready,
    output logic [CMD_WIDTH-1:0]     M_AXIS_CMD_tdata,
    output logic                     M_AXIS_CMD_tvalid,
    input  logic                     M_AXIS_CMD_tready,
    output logic [SDDT_PEND_W-1:0]   ref_pending,
    output logic [SDDT_ISSUED_W-1:0] ref_issued,
    output logic                     ref_overflow
);

    localparam logic [SDDT_PEND_W-1:0] PEND_MAX = SDDT_PEND_W'(MAX_POSTPONE);

    arb_state_t               state_c;
    logic                     load_ok_c;
    logic                     host_take_c;
    logic                     ref_issue_c;

    logic                     out_valid_q, out_valid_d;
    logic                     out_is_ref_q, out_is_ref_d;
    logic [CMD_WIDTH-1:0]     out_data_q, out_data_d;
    logic [SDDT_ISSUED_W-1:0] issued_q, issued_d;

    sddt_ref_timer #(
        .TREFI_CYCLES (TREFI_CYCLES),
        .MAX_POSTPONE (MAX_POSTPONE)
    ) u_ref_timer (
        .c0_ddr4_clk  (c0_ddr4_clk),
        .c0_ddr4_rst  (c0_ddr4_rst),
        .ref_en       (ref_en),
        .ref_issue    (ref_issue_c),
        .ref_pending  (ref_pending),
        .ref_overflow (ref_overflow)
    );

    // State is decoded from the registered debt so it never lags it by a cycle;
    // dropping ref_en returns to NORMAL immediately.
    always_comb begin
        state_c     = (ref_en && (ref_pending >= PEND_MAX)) ? URGENT : NORMAL;
        load_ok_c   = !out_valid_q || M_AXIS_CMD_tready;
        host_take_c = !c0_ddr4_rst && load_ok_c && (state_c == NORMAL) && S_AXIS_HOST_tvalid;
        ref_issue_c = !c0_ddr4_rst && load_ok_c && ref_en && (ref_pending != '0) && !host_take_c;
    end

    assign S_AXIS_HOST_tready = !c0_ddr4_rst && load_ok_c && (state_c == NORMAL);

    // Output slot next state and refresh hand-off counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_is_ref_d = out_is_ref_q;
        out_data_d   = out_data_q;
        issued_d     = issued_q;
        if (load_ok_c) begin
            if (host_take_c) begin
                out_valid_d  = 1'b1;
                out_is_ref_d = 1'b0;
                out_data_d   = S_AXIS_HOST_tdata;
            end else if (ref_issue_c) begin
                out_valid_d  = 1'b1;
                out_is_ref_d = 1'b1;
                out_data_d   = REF_CMD;
            end else begin
                out_valid_d  = 1'b0;
                out_is_ref_d = 1'b0;
            end
        end
        // Tracked by flag, not data, so a host word equal to REF_CMD is not counted.
        if (out_valid_q && M_AXIS_CMD_tready && out_is_ref_q) begin
            issued_d = issued_q + SDDT_ISSUED_W'(1);
        end
    end

    always_ff @(posedge c0_ddr4_clk) begin
        if (c0_ddr4_rst) begin
            out_valid_q  <= 1'b0;
            out_is_ref_q <= 1'b0;
            out_data_q   <= '0;
            issued_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_is_ref_q <= out_is_ref_d;
            out_data_q   <= out_data_d;
            issued_q     <= issued_d;
        end
    end

    assign M_AXIS_CMD_tvalid = out_valid_q;
    assign M_AXIS_CMD_tdata  = out_data_q;
    assign ref_issued        = issued_q;

endmodule

// File: tb/tb_sddt_cmd_arbiter.sv
// Scoreboard bench for sddt_cmd_arbiter with TREFI_CYCLES=16, MAX_POSTPONE=8.
module tb_sddt_cmd_arbiter;

    localparam int unsigned W     = 128;
    localparam int unsigned TREFI = 16;
    localparam int unsigned MAXP  = 8;
    localparam logic [W-1:0] REF_W = {4'h3, 124'h0};

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } host_exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         ref_en;
    logic [W-1:0] hd;
    logic         hv;
    logic         s_tready;
    logic [W-1:0] m_tdata;
    logic         m_tvalid;
    logic         mr;
    logic [3:0]   pend;
    logic [31:0]  issued;
    logic         ovf;

    int cyc          = 0;
    int n_tests      = 0;
    int n_fail       = 0;
    int n_host_beats = 0;
    int base;
    int beats0;
    logic [3:0] pmax;

    host_exp_t host_q[$];
    int        ref_q[$];

    sddt_cmd_arbiter #(
        .CMD_WIDTH    (W),
        .TREFI_CYCLES (TREFI),
        .MAX_POSTPONE (MAXP)
    ) dut (
        .c0_ddr4_clk        (clk),
        .c0_ddr4_rst        (rst),
        .ref_en             (ref_en),
        .S_AXIS_HOST_tdata  (hd),
        .S_AXIS_HOST_tvalid (hv),
        .S_AXIS_HOST_tready (s_tready),
        .M_AXIS_CMD_tdata   (m_tdata),
        .M_AXIS_CMD_tvalid  (m_tvalid),
        .M_AXIS_CMD_tready  (mr),
        .ref_pending        (pend),
        .ref_issued         (issued),
        .ref_overflow       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every M handshake is matched against the scoreboard queues.
    host_exp_t mon_e;
    int        mon_due;
    always @(negedge clk) begin
        if (!rst && m_tvalid && mr) begin
            if (m_tdata == REF_W) begin
                if (ref_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ref: got refresh beat, expected none (cycle %0d)", cyc);
                end else begin
                    mon_due = ref_q.pop_front();
                    chk("ref_beat_cycle", W'(cyc), W'(mon_due));
                end
            end else begin
                n_host_beats++;
                if (host_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_host: got %0h, expected no beat (cycle %0d)", m_tdata, cyc);
                end else begin
                    mon_e = host_q.pop_front();
                    chk("host_data", m_tdata, mon_e.data);
                    if (mon_e.due >= 0) chk("host_latency", W'(cyc), W'(mon_e.due));
                end
            end
        end
    end

    // Land on the first negedge whose cycle index is >= t.
    task automatic wait_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    // Land just after the posedge that starts cycle t.
    task automatic to_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic host_send(input logic [W-1:0] w, input bit lat);
        int n;
        n  = 0;
        hd = w;
        hv = 1'b1;
        forever begin
            @(negedge clk);
            if (s_tready) begin
                host_q.push_back('{data: w, due: lat ? cyc + 1 : -1});
                @(posedge clk);
                #1;
                break;
            end
            n++;
            if (n > 400) begin
                n_tests++;
                n_fail++;
                $display("FAIL host_accept_timeout: word %0h not accepted in 400 cycles", w);
                break;
            end
            @(posedge clk);
            #1;
        end
        hv = 1'b0;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        hv     = 1'b0;
        ref_en = 1'b0;
        mr     = 1'b1;
        host_q.delete();
        ref_q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic phase_end(input string name);
        chk({name, "_host_q_empty"}, W'(host_q.size()), W'(0));
        chk({name, "_ref_q_empty"}, W'(ref_q.size()), W'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        ref_en = 1'b1;
        hv     = 1'b1;
        hd     = W'(128'h55);
        mr     = 1'b1;

        // Reset state, with host valid and ref_en asserted during reset.
        @(negedge clk);
        chk("rst_m_tvalid", W'(m_tvalid), W'(1'b0));
        chk("rst_m_tdata", m_tdata, W'(0));
        chk("rst_s_tready", W'(s_tready), W'(1'b0));
        chk("rst_pending", W'(pend), W'(4'd0));
        chk("rst_issued", W'(issued), W'(32'd0));
        chk("rst_overflow", W'(ovf), W'(1'b0));
        @(posedge clk);
        #1;
        do_reset();

        // Passthrough: refresh disabled, 20 back-to-back host words.
        base   = cyc;
        beats0 = n_host_beats;
        for (int i = 0; i < 20; i++) host_send(W'(i), 1'b1);
        wait_neg(base + 22);
        chk("pt_beats", W'(n_host_beats - beats0), W'(20));
        chk("pt_issued", W'(issued), W'(32'd0));
        chk("pt_pending", W'(pend), W'(4'd0));
        phase_end("pt");
        do_reset();

        // Idle refresh: one refresh per interval, debt never above 1.
        base   = cyc;
        ref_en = 1'b1;
        for (int k = 0; k < 4; k++) ref_q.push_back(base + 17 + 16 * k);
        pmax = 4'd0;
        for (int i = 0; i <= 70; i++) begin
            wait_neg(base + i);
            if (pend > pmax) pmax = pend;
            if (i == 15) chk("idle_pend_before_tick", W'(pend), W'(4'd0));
            if (i == 16) chk("idle_pend_after_tick", W'(pend), W'(4'd1));
            if (i == 17) chk("idle_pend_after_issue", W'(pend), W'(4'd0));
        end
        chk("idle_pend_peak", W'(pmax), W'(4'd1));
        chk("idle_issued", W'(issued), W'(32'd4));
        to_cycle(base + 71);
        ref_en = 1'b0;
        phase_end("idle");
        do_reset();

        // Tick and issue in the same cycle at debt 3.
        base   = cyc;
        ref_en = 1'b1;
        for (int k = 0; k < 4; k++) ref_q.push_back(base + 64 + k);
        for (int i = 0; i < 63; i++) host_send(W'(1000 + i), 1'b1);
        wait_neg(base + 63);
        chk("sim_pend_pre", W'(pend), W'(4'd3));
        wait_neg(base + 64);
        chk("sim_pend_hold", W'(pend), W'(4'd3));
        wait_neg(base + 67);
        chk("sim_pend_drained", W'(pend), W'(4'd0));
        to_cycle(base + 70);
        ref_en = 1'b0;
        wait_neg(base + 72);
        chk("sim_issued", W'(issued), W'(32'd4));
        phase_end("sim");
        do_reset();

        // Postpone under continuous host traffic, then urgent refresh.
        base   = cyc;
        ref_en = 1'b1;
        ref_q.push_back(base + 129);
        ref_q.push_back(base + 145);
        fork
            begin
                for (int i = 0; i < 150; i++) host_send(W'(2000 + i), 1'b1);
            end
            begin
                wait_neg(base + 127);
                chk("pp_tready_pre", W'(s_tready), W'(1'b1));
                chk("pp_pend_pre", W'(pend), W'(4'd7));
                wait_neg(base + 128);
                chk("pp_tready_urgent", W'(s_tready), W'(1'b0));
                chk("pp_pend_max", W'(pend), W'(4'd8));
                wait_neg(base + 129);
                chk("pp_tready_resume", W'(s_tready), W'(1'b1));
                chk("pp_pend_after", W'(pend), W'(4'd7));
            end
        join
        ref_en = 1'b0;
        wait_neg(base + 155);
        chk("pp_pend_retained", W'(pend), W'(4'd7));
        chk("pp_issued", W'(issued), W'(32'd2));
        chk("pp_overflow", W'(ovf), W'(1'b0));
        phase_end("pp");
        do_reset();

        // Overflow under sustained back-pressure, then drain.
        base   = cyc;
        ref_en = 1'b1;
        mr     = 1'b0;
        host_send(W'(128'hA5A5_0000_1111_2222_3333_4444_5555_6666), 1'b0);
        hd = W'(128'h0BAD);
        hv = 1'b1;
        for (int i = 1; i <= 160; i++) begin
            wait_neg(base + i);
            chk("ovf_hold_valid", W'(m_tvalid), W'(1'b1));
            chk("ovf_hold_data", m_tdata, W'(128'hA5A5_0000_1111_2222_3333_4444_5555_6666));
            if (i <= 10) chk("ovf_tready_low", W'(s_tready), W'(1'b0));
            if (i == 10) hv = 1'b0;
            if (i == 127) chk("ovf_pend_7", W'(pend), W'(4'd7));
            if (i == 128) chk("ovf_pend_8", W'(pend), W'(4'd8));
            if (i == 143) chk("ovf_flag_pre", W'(ovf), W'(1'b0));
            if (i == 144) chk("ovf_flag_set", W'(ovf), W'(1'b1));
        end
        chk("ovf_pend_sat", W'(pend), W'(4'd8));
        chk("ovf_flag", W'(ovf), W'(1'b1));
        for (int k = 0; k < 8; k++) ref_q.push_back(base + 162 + k);
        to_cycle(base + 161);
        mr = 1'b1;
        to_cycle(base + 170);
        ref_en = 1'b0;
        wait_neg(base + 172);
        chk("ovf_drain_issued", W'(issued), W'(32'd8));
        chk("ovf_drain_pend", W'(pend), W'(4'd0));
        chk("ovf_flag_sticky", W'(ovf), W'(1'b1));
        phase_end("ovf");
        do_reset();

        // Reset while a host word is held by back-pressure.
        @(negedge clk);
        chk("rr_ovf_cleared", W'(ovf), W'(1'b0));
        chk("rr_issued_cleared", W'(issued), W'(32'd0));
        to_cycle(cyc + 1);
        base = cyc;
        mr   = 1'b0;
        host_send(W'(128'hC0FFEE), 1'b0);
        to_cycle(base + 3);
        rst = 1'b1;
        host_q.delete();
        wait_neg(base + 3);
        chk("rr_tready_in_reset", W'(s_tready), W'(1'b0));
        wait_neg(base + 4);
        chk("rr_tvalid", W'(m_tvalid), W'(1'b0));
        chk("rr_tdata", m_tdata, W'(0));
        chk("rr_pending", W'(pend), W'(4'd0));
        chk("rr_issued", W'(issued), W'(32'd0));
        chk("rr_overflow", W'(ovf), W'(1'b0));
        to_cycle(base + 5);
        rst = 1'b0;
        mr  = 1'b1;
        wait_neg(base + 12);
        chk("rr_no_emit", W'(m_tvalid), W'(1'b0));
        phase_end("rr");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
